// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register offsets,
// register-select decode and byte-enable expansion.
package int_ctrl_pkg;

    localparam int unsigned INTC_NUM_OUT = 6;

    localparam logic [7:0] INTC_RAW     = 8'h00;
    localparam logic [7:0] INTC_PENDING = 8'h04;
    localparam logic [7:0] INTC_ENABLE  = 8'h08;
    localparam logic [7:0] INTC_EDGE    = 8'h0C;
    localparam logic [7:0] INTC_POL     = 8'h10;
    localparam logic [7:0] INTC_SWSET   = 8'h14;
    localparam logic [7:0] INTC_ROUTE0  = 8'h20;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAW,
        SEL_PENDING,
        SEL_ENABLE,
        SEL_EDGE,
        SEL_POL,
        SEL_SWSET,
        SEL_ROUTE
    } reg_sel_e;

    // addr must already be word aligned
    function automatic reg_sel_e decode_sel(input logic [7:0] addr);
        reg_sel_e sel;
        case (addr)
            INTC_RAW:     sel = SEL_RAW;
            INTC_PENDING: sel = SEL_PENDING;
            INTC_ENABLE:  sel = SEL_ENABLE;
            INTC_EDGE:    sel = SEL_EDGE;
            INTC_POL:     sel = SEL_POL;
            INTC_SWSET:   sel = SEL_SWSET;
            default: begin
                if (addr >= INTC_ROUTE0 && addr < INTC_ROUTE0 + 8'(4 * INTC_NUM_OUT))
                    sel = SEL_ROUTE;
                else
                    sel = SEL_NONE;
            end
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] wen);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++)
            m[8*b +: 8] = {8{wen[b]}};
        return m;
    endfunction

endpackage

// File: rtl/int_ctrl_src_cell.sv
// One interrupt source: 2-flop synchroniser, polarity, history and the
// level/edge pending flop.
module intc_src_cell (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic edge_mode,
    input  logic pol,
    input  logic pol_next,
    input  logic cfg_wr,
    input  logic clr,
    input  logic swset,
    output logic adj,
    output logic pending
);

    logic s1;
    logic s2;
    logic hist;

    assign adj = s2 ^ pol;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            hist    <= 1'b0;
            pending <= 1'b0;
        end else begin
            s1 <= src;
            s2 <= s1;
            // A config write preloads history with the post-write adj so the
            // polarity flip itself never looks like an edge.
            hist <= cfg_wr ? (s2 ^ pol_next) : adj;
            if (edge_mode)
                pending <= (adj & ~hist) | swset | (pending & ~clr);
            else
                pending <= adj;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// External interrupt controller: register file, bus decode, read mux and
// per-line route reduction onto the CPU hardware interrupt lines.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned NUM_OUT = INTC_NUM_OUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               bus_en,
    input  logic [3:0]         bus_wen,
    input  logic [7:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic [NUM_OUT-1:0] hw_int
);

    logic               wr;
    logic               rd;
    logic [7:0]         aligned_addr;
    logic [7:0]         route_off;
    logic [2:0]         route_idx;
    reg_sel_e           sel;
    logic [31:0]        bmask32;
    logic [NUM_SRC-1:0] wmask;
    logic [NUM_SRC-1:0] wdata_src;

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] edge_cfg;
    logic [NUM_SRC-1:0] pol;
    logic [NUM_SRC-1:0] route [NUM_OUT];
    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] pending;

    logic [NUM_SRC-1:0] pol_new;
    logic [NUM_SRC-1:0] edge_new;
    logic [NUM_SRC-1:0] cfg_wr;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] swset;
    logic [NUM_SRC-1:0] rd_src;
    logic [31:0]        rd_word;

    logic               unused_bits;

    function automatic logic [NUM_SRC-1:0] merge(
        input logic [NUM_SRC-1:0] old_v,
        input logic [NUM_SRC-1:0] new_v,
        input logic [NUM_SRC-1:0] m
    );
        return (old_v & ~m) | (new_v & m);
    endfunction

    assign wr           = bus_en & (|bus_wen);
    assign rd           = bus_en & ~(|bus_wen);
    assign aligned_addr = {bus_addr[7:2], 2'b00};
    assign sel          = decode_sel(aligned_addr);
    assign route_off    = aligned_addr - INTC_ROUTE0;
    assign route_idx    = route_off[4:2];
    assign bmask32      = byte_mask(bus_wen);
    assign wmask        = bmask32[NUM_SRC-1:0];
    assign wdata_src    = bus_wdata[NUM_SRC-1:0];
    assign unused_bits  = ^{bus_addr[1:0], bus_wdata, bmask32, route_off};

    always_comb begin
        pol_new  = pol;
        edge_new = edge_cfg;
        cfg_wr   = '0;
        clr      = '0;
        swset    = '0;
        if (wr) begin
            case (sel)
                SEL_POL: begin
                    pol_new = merge(pol, wdata_src, wmask);
                    cfg_wr  = wmask;
                end
                SEL_EDGE: begin
                    edge_new = merge(edge_cfg, wdata_src, wmask);
                    cfg_wr   = wmask;
                end
                SEL_PENDING: clr   = wdata_src & wmask;
                SEL_SWSET:   swset = wdata_src & wmask;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        intc_src_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .src       (src_irq[i]),
            .edge_mode (edge_cfg[i]),
            .pol       (pol[i]),
            .pol_next  (pol_new[i]),
            .cfg_wr    (cfg_wr[i]),
            .clr       (clr[i]),
            .swset     (swset[i]),
            .adj       (raw[i]),
            .pending   (pending[i])
        );
    end

    always_comb begin
        rd_src = '0;
        case (sel)
            SEL_RAW:     rd_src = raw;
            SEL_PENDING: rd_src = pending;
            SEL_ENABLE:  rd_src = enable;
            SEL_EDGE:    rd_src = edge_cfg;
            SEL_POL:     rd_src = pol;
            SEL_ROUTE: begin
                for (int unsigned k = 0; k < NUM_OUT; k++)
                    if (route_idx == 3'(k))
                        rd_src = route[k];
            end
            default: ;
        endcase
        rd_word = '0;
        rd_word[NUM_SRC-1:0] = rd_src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= '0;
            edge_cfg  <= '0;
            pol       <= '0;
            bus_rdata <= '0;
            hw_int    <= '0;
            for (int unsigned k = 0; k < NUM_OUT; k++)
                route[k] <= '0;
        end else begin
            pol      <= pol_new;
            edge_cfg <= edge_new;
            if (wr && sel == SEL_ENABLE)
                enable <= merge(enable, wdata_src, wmask);
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                if (wr && sel == SEL_ROUTE && route_idx == 3'(k))
                    route[k] <= merge(route[k], wdata_src, wmask);
                hw_int[k] <= |(pending & enable & route[k]);
            end
            if (rd)
                bus_rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: reset, level/edge latency,
// W1C, set-vs-clear, polarity switch, masking and byte enables.
module tb_int_ctrl;

    localparam int unsigned NSRC = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src_irq;
    logic            bus_en;
    logic [3:0]      bus_wen;
    logic [7:0]      bus_addr;
    logic [31:0]     bus_wdata;
    logic [31:0]     bus_rdata;
    logic [5:0]      hw_int;

    int passed = 0;
    int checks = 0;
    logic [31:0] rv;

    int_ctrl #(.NUM_SRC(NSRC), .NUM_OUT(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_irq   (src_irq),
        .bus_en    (bus_en),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .hw_int    (hw_int)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
        bus_en = 1'b1; bus_wen = w; bus_addr = a; bus_wdata = d;
        tick();
        bus_en = 1'b0; bus_wen = 4'h0; bus_wdata = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus_en = 1'b1; bus_wen = 4'h0; bus_addr = a;
        tick();
        bus_en = 1'b0;
        d = bus_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; src_irq = 16'hFFFF;
        bus_en = 1'b0; bus_wen = 4'h0; bus_addr = 8'h00; bus_wdata = '0;
        ticks(3);
        check("rst_hw_int", 32'(hw_int), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        bus_read(8'h00, rv);
        check("rst_read_raw", rv, 32'h0);

        reset = 1'b0;
        ticks(4);
        bus_read(8'h00, rv);       check("raw_ffff", rv, 32'h0000FFFF);
        bus_read(8'h04, rv);       check("pend_level_ffff", rv, 32'h0000FFFF);
        bus_read(8'h08, rv);       check("enable_rst", rv, 32'h0);
        bus_read(8'h0C, rv);       check("edge_rst", rv, 32'h0);
        bus_read(8'h10, rv);       check("pol_rst", rv, 32'h0);
        check("hw_int_unrouted", 32'(hw_int), 32'h0);
        src_irq = '0;
        ticks(4);
        bus_read(8'h04, rv);       check("pend_level_clear", rv, 32'h0);

        // Level source routed to hw_int[5]
        bus_write(8'h08, 32'h1, 4'hF);
        bus_write(8'h34, 32'h1, 4'hF);
        src_irq[0] = 1'b1;
        ticks(3);
        check("lvl_rise_n2", 32'(hw_int), 32'h0);
        tick();
        check("lvl_rise_n3", 32'(hw_int), 32'h20);
        src_irq[0] = 1'b0;
        ticks(3);
        check("lvl_fall_n2", 32'(hw_int), 32'h20);
        tick();
        check("lvl_fall_n3", 32'(hw_int), 32'h0);

        // Edge source routed to hw_int[0]
        bus_write(8'h0C, 32'h4, 4'hF);
        bus_write(8'h08, 32'h4, 4'hF);
        bus_write(8'h20, 32'h4, 4'hF);
        src_irq[2] = 1'b1;
        tick();
        src_irq[2] = 1'b0;
        ticks(3);
        check("edge_hw_set", 32'(hw_int), 32'h01);
        ticks(5);
        check("edge_hw_hold", 32'(hw_int), 32'h01);
        bus_read(8'h04, rv);       check("edge_pend", rv, 32'h4);
        bus_write(8'h04, 32'h4, 4'hF);
        check("w1c_hw_lag", 32'(hw_int), 32'h01);
        tick();
        check("w1c_hw_clear", 32'(hw_int), 32'h0);

        // New edge coincides with W1C of the same bit
        src_irq[2] = 1'b1;
        ticks(2);
        bus_write(8'h04, 32'h4, 4'hF);
        src_irq[2] = 1'b0;
        bus_read(8'h04, rv);       check("set_beats_clr", rv, 32'h4);
        bus_write(8'h04, 32'h4, 4'hF);
        bus_read(8'h04, rv);       check("clr_after", rv, 32'h0);

        // Polarity switch on an edge source
        bus_write(8'h0C, 32'h8, 4'hF);
        bus_write(8'h10, 32'h8, 4'hF);
        ticks(2);
        bus_read(8'h00, rv);       check("pol_raw", rv, 32'h8);
        bus_read(8'h04, rv);       check("pol_no_spurious", rv, 32'h0);
        src_irq[3] = 1'b1;
        ticks(4);
        bus_read(8'h04, rv);       check("pol_rise_ignored", rv, 32'h0);
        src_irq[3] = 1'b0;
        ticks(4);
        bus_read(8'h04, rv);       check("pol_fall_sets", rv, 32'h8);

        // Masking, SWSET and byte enables
        bus_write(8'h0C, 32'h18, 4'hF);
        bus_write(8'h08, 32'h0, 4'hF);
        bus_write(8'h14, 32'h10, 4'hF);
        bus_write(8'h24, 32'h10, 4'hF);
        bus_read(8'h04, rv);       check("swset_pend", rv, 32'h18);
        bus_read(8'h14, rv);       check("swset_reads0", rv, 32'h0);
        check("masked_hw", 32'(hw_int), 32'h0);
        bus_write(8'h08, 32'hFFFF_FF10, 4'b0001);
        bus_read(8'h08, rv);       check("en_byte0", rv, 32'h10);
        check("en_hw_route1", 32'(hw_int), 32'h02);
        ticks(2);
        check("rdata_hold", bus_rdata, 32'h10);
        bus_read(8'h18, rv);       check("unmapped_read", rv, 32'h0);
        bus_write(8'h08, 32'h0000_AB00, 4'b0010);
        bus_read(8'h08, rv);       check("en_byte1", rv, 32'hAB10);
        bus_write(8'h28, 32'hFFFF_FFFF, 4'hF);
        bus_read(8'h28, rv);       check("route2_width", rv, 32'h0000FFFF);
        bus_write(8'h18, 32'hFFFF_FFFF, 4'hF);
        bus_read(8'h18, rv);       check("unmapped_write", rv, 32'h0);

        // Reset mid-operation
        reset = 1'b1;
        tick();
        check("midrst_hw", 32'(hw_int), 32'h0);
        check("midrst_rdata", bus_rdata, 32'h0);
        reset = 1'b0;
        bus_read(8'h04, rv);       check("midrst_pend", rv, 32'h0);
        bus_read(8'h08, rv);       check("midrst_enable", rv, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
